// File: rtl/pe_result_collector.sv
// Collects lane-packed results from a vectorized PE into a first-word-fall-through FIFO
// and presents them as an AXI-Stream master with byte keep and packet-end markers.
module pe_result_collector #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFULL_THRESH = 12,
  parameter int unsigned SIMD_degree  = 4,
  parameter int unsigned dwidth_float = 32,
  parameter int unsigned phit_size    = SIMD_degree * dwidth_float
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [phit_size-1:0]   i_PE_data,
  input  logic [SIMD_degree-1:0] i_PE_tvalid,
  input  logic [SIMD_degree-1:0] i_PE_tlast,

  output logic [phit_size-1:0]   m_axis_tdata,
  output logic [phit_size/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,

  output logic                   o_almost_full,
  output logic                   o_overflow,
  output logic [31:0]            o_pkt_count
);

  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned KeepW     = phit_size / 8;
  localparam int unsigned LaneBytes = dwidth_float / 8;

  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntAfull = CntW'(AFULL_THRESH);

  logic [phit_size-1:0] data_mem [FIFO_DEPTH];
  logic [KeepW-1:0]     keep_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            afull_q, ovf_q, ovf_d;
  logic [31:0]     pkt_q, pkt_d;

  logic [KeepW-1:0] keep_in;
  logic             last_in;
  logic             push, pop, full, accept, not_empty;

  // Entry formation: each lane's valid widens to that lane's bytes.
  always_comb begin
    keep_in = '0;
    for (int i = 0; i < int'(SIMD_degree); i++) begin
      keep_in[i*LaneBytes +: LaneBytes] = {LaneBytes{i_PE_tvalid[i]}};
    end
    last_in = |(i_PE_tvalid & i_PE_tlast);
  end

  assign push      = |i_PE_tvalid;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CntFull);
  assign pop       = not_empty & m_axis_tready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept    = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    pkt_d    = pkt_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (last_mem[rd_ptr_q]) begin
        pkt_d = pkt_q + 32'd1;
      end
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (push && !accept) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= (count_d >= CntAfull);
      ovf_q    <= ovf_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage is not reset; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      data_mem[wr_ptr_q] <= i_PE_data;
      keep_mem[wr_ptr_q] <= keep_in;
      last_mem[wr_ptr_q] <= last_in;
    end
  end

  assign m_axis_tvalid = not_empty;
  assign m_axis_tdata  = not_empty ? data_mem[rd_ptr_q] : '0;
  assign m_axis_tkeep  = not_empty ? keep_mem[rd_ptr_q] : '0;
  assign m_axis_tlast  = not_empty & last_mem[rd_ptr_q];

  assign o_almost_full = afull_q;
  assign o_overflow    = ovf_q;
  assign o_pkt_count   = pkt_q;

endmodule
